// File: rtl/psg_pkg.sv
// psg_pkg: shared constants, sample type and helpers for the multi-PSG mixer and its cores.
package psg_pkg;

   localparam int unsigned MAX_CHIPS  = 8;
   localparam logic [4:0]  SEL_PREFIX = 5'b11111;

   typedef logic [7:0] psg_sample_t;

   // ceil(log2(n)) for a mix-set size n in 1..8
   function automatic logic [1:0] mix_shift(input logic [3:0] n);
      if (n <= 4'd1) begin
         return 2'd0;
      end else if (n == 4'd2) begin
         return 2'd1;
      end else if (n <= 4'd4) begin
         return 2'd2;
      end else begin
         return 2'd3;
      end
   endfunction

   // Logarithmic 4-bit amplitude to 8-bit sample (roughly 3 dB per step)
   function automatic psg_sample_t vol_level(input logic [3:0] v);
      case (v)
         4'd0:    return 8'd0;
         4'd1:    return 8'd2;
         4'd2:    return 8'd3;
         4'd3:    return 8'd4;
         4'd4:    return 8'd6;
         4'd5:    return 8'd8;
         4'd6:    return 8'd11;
         4'd7:    return 8'd16;
         4'd8:    return 8'd22;
         4'd9:    return 8'd32;
         4'd10:   return 8'd45;
         4'd11:   return 8'd64;
         4'd12:   return 8'd90;
         4'd13:   return 8'd128;
         4'd14:   return 8'd181;
         default: return 8'd255;
      endcase
   endfunction

endpackage

// File: rtl/psg_activity_hold.sv
// psg_activity_hold: per-chip "in the mix" flag with a hold-off after the last activity.
// Optional macro MULTI_PSG_HOLD_EN: when defined, a down-counter keeps the chip in the mix
// for HOLD_CYC CE ticks after activity ends; when undefined, the flag follows activity directly.
module psg_activity_hold #(
   parameter int unsigned HOLD_CYC = 1024
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       CE,
   input  logic [5:0] ACTIVE,
   output logic       PLAYING
);

`ifdef MULTI_PSG_HOLD_EN
   localparam int unsigned CNT_W = $clog2(HOLD_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Activity reloads the counter and wins over CE; otherwise count down on CE
   always_comb begin
      cnt_d = cnt_q;
      if (|ACTIVE) begin
         cnt_d = CNT_W'(HOLD_CYC);
      end else if (CE && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Hold counter register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign PLAYING = (|ACTIVE) | (cnt_q != '0);
`else
   logic unused_hold;

   assign PLAYING     = |ACTIVE;
   assign unused_hold = ^{CLK, RESET_N, CE, HOLD_CYC[0]};
`endif

endmodule

// File: rtl/ym2149.sv
// ym2149: compact PSG core -- 16 registers, three tone generators, one noise LFSR,
// per-channel mixer and log volume. The envelope generator is not modelled; the
// envelope bit of the volume registers is stored for readback only.
// CS gates all bus activity so several cores can share BDIR/DI.
module ym2149
   import psg_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CE,
   input  logic        CS,
   input  logic        BDIR,
   input  logic        BC,
   input  logic [7:0]  DI,
   output logic [7:0]  DO,
   input  logic        SEL,
   input  logic        MODE,
   input  logic [7:0]  IOA_in,
   output logic [7:0]  IOA_out,
   input  logic [7:0]  IOB_in,
   output logic [7:0]  IOB_out,
   output logic [5:0]  ACTIVE,
   output psg_sample_t CHANNEL_A,
   output psg_sample_t CHANNEL_B,
   output psg_sample_t CHANNEL_C
);

   logic [7:0]  regs_q [16];
   logic [7:0]  regs_d [16];
   logic [3:0]  addr_q, addr_d;
   logic        addr_ok_q, addr_ok_d;
   logic        ce_div_q, ce_div_d;
   logic [11:0] tone_cnt_q [3];
   logic [11:0] tone_cnt_d [3];
   logic [2:0]  tone_q, tone_d;
   logic [4:0]  noise_cnt_q, noise_cnt_d;
   logic [16:0] lfsr_q, lfsr_d;
   logic        ce_int;
   logic [11:0] tone_per;
   logic [7:0]  rd;
   logic [2:0]  gate;
   psg_sample_t level [3];

   // SEL=0 halves the generator rate
   assign ce_int = CE & (SEL | ce_div_q);

   // AY-mode readback keeps only the implemented bits of each register
   function automatic logic [7:0] rd_mask(input logic [3:0] a);
      case (a)
         4'd1, 4'd3, 4'd5, 4'd13: return 8'h0F;
         4'd6, 4'd8, 4'd9, 4'd10: return 8'h1F;
         default:                 return 8'hFF;
      endcase
   endfunction

   // Bus decode plus tone/noise generator next state
   always_comb begin
      regs_d      = regs_q;
      addr_d      = addr_q;
      addr_ok_d   = addr_ok_q;
      ce_div_d    = ce_div_q ^ CE;
      tone_cnt_d  = tone_cnt_q;
      tone_d      = tone_q;
      noise_cnt_d = noise_cnt_q;
      lfsr_d      = lfsr_q;
      tone_per    = '0;
      if (CS && BDIR) begin
         if (BC) begin
            // An address with a non-zero high nibble deselects the register file
            addr_d    = DI[3:0];
            addr_ok_d = (DI[7:4] == 4'h0);
         end else if (addr_ok_q) begin
            regs_d[addr_q] = DI;
         end
      end
      if (ce_int) begin
         for (int c = 0; c < 3; c++) begin
            tone_per = {regs_q[2*c+1][3:0], regs_q[2*c]};
            // A period of 0 behaves like 1
            if ({1'b0, tone_cnt_q[c]} + 13'd1 >= {1'b0, tone_per}) begin
               tone_cnt_d[c] = '0;
               tone_d[c]     = ~tone_q[c];
            end else begin
               tone_cnt_d[c] = tone_cnt_q[c] + 12'd1;
            end
         end
         if ({1'b0, noise_cnt_q} + 6'd1 >= {1'b0, regs_q[6][4:0]}) begin
            noise_cnt_d = '0;
            lfsr_d      = {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
         end else begin
            noise_cnt_d = noise_cnt_q + 5'd1;
         end
      end
   end

   // Core state; the mixer register resets with all channels and noise disabled
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int r = 0; r < 16; r++) begin
            regs_q[r] <= (r == 7) ? 8'h3F : 8'h00;
         end
         addr_q      <= '0;
         addr_ok_q   <= 1'b0;
         ce_div_q    <= 1'b0;
         for (int c = 0; c < 3; c++) begin
            tone_cnt_q[c] <= '0;
         end
         tone_q      <= '0;
         noise_cnt_q <= '0;
         lfsr_q      <= 17'd1;
      end else begin
         regs_q      <= regs_d;
         addr_q      <= addr_d;
         addr_ok_q   <= addr_ok_d;
         ce_div_q    <= ce_div_d;
         tone_cnt_q  <= tone_cnt_d;
         tone_q      <= tone_d;
         noise_cnt_q <= noise_cnt_d;
         lfsr_q      <= lfsr_d;
      end
   end

   // Register readback; I/O registers read the pins when the port is an input
   always_comb begin
      rd = regs_q[addr_q];
      if ((addr_q == 4'd14) && !regs_q[7][6]) begin
         rd = IOA_in;
      end
      if ((addr_q == 4'd15) && !regs_q[7][7]) begin
         rd = IOB_in;
      end
      if (MODE) begin
         rd = rd & rd_mask(addr_q);
      end
      DO = rd;
   end

   // Channel mixer: a disabled source counts as permanently high
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         gate[c]  = (tone_q[c] | regs_q[7][c]) & (lfsr_q[0] | regs_q[7][3+c]);
         level[c] = gate[c] ? vol_level(regs_q[8+c][3:0]) : '0;
      end
   end

   assign CHANNEL_A = level[0];
   assign CHANNEL_B = level[1];
   assign CHANNEL_C = level[2];
   assign ACTIVE    = ~regs_q[7][5:0];
   assign IOA_out   = regs_q[14];
   assign IOB_out   = regs_q[15];

endmodule

// File: rtl/multi_psg.sv
// multi_psg: N-chip TurboSound-style PSG array with chip select, readback routing and a
// count-normalised mixer. Optional macro MULTI_PSG_HOLD_EN keeps a chip in the mix for
// HOLD_CYC CE ticks after its last activity.
module multi_psg
   import psg_pkg::*;
#(
   parameter int unsigned NCHIPS   = 2,
   parameter int unsigned HOLD_CYC = 1024
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              CE,
   input  logic              BDIR,
   input  logic              BC,
   input  logic [7:0]        DI,
   output logic [7:0]        DO,
   input  logic              SEL,
   input  logic              MODE,
   input  logic [7:0]        IOA_in,
   input  logic [7:0]        IOB_in,
   output logic [7:0]        IOA_out,
   output logic [7:0]        IOB_out,
   output logic [7:0]        CHANNEL_A,
   output logic [7:0]        CHANNEL_B,
   output logic [7:0]        CHANNEL_C,
   output logic [2:0]        SELECTED,
   output logic [NCHIPS-1:0] PLAYING
);

   if ((NCHIPS < 1) || (NCHIPS > MAX_CHIPS)) begin : g_bad_nchips
      $error("multi_psg: NCHIPS must be in 1..8");
   end

   logic              select_cmd;
   logic              fwd_en;
   logic [2:0]        idx;
   logic [2:0]        sel_q, sel_d;
   psg_sample_t       chan_a_q, chan_a_d;
   psg_sample_t       chan_b_q, chan_b_d;
   psg_sample_t       chan_c_q, chan_c_d;
   psg_sample_t       ch_a [NCHIPS];
   psg_sample_t       ch_b [NCHIPS];
   psg_sample_t       ch_c [NCHIPS];
   logic [7:0]        do_w [NCHIPS];
   logic [5:0]        active_w [NCHIPS];
   logic [NCHIPS-1:0][7:0] ioa_w;
   logic [NCHIPS-1:0][7:0] iob_w;
   logic [3:0]        n_mix;
   logic [1:0]        shift;
   logic [10:0]       sum_a, sum_b, sum_c;
   logic              unused_io;

   // 0xFF selects chip 0, 0xFE chip 1, ...; the command itself never reaches a core
   assign idx        = DI[2:0] ^ 3'b111;
   assign select_cmd = BDIR & BC & (DI[7:3] == SEL_PREFIX);
   assign fwd_en     = ~select_cmd;

   // Chip select: out-of-range indices leave the selection alone
   always_comb begin
      sel_d = sel_q;
      if (select_cmd && (32'(idx) < NCHIPS)) begin
         sel_d = idx;
      end
   end

   for (genvar i = 0; i < NCHIPS; i++) begin : g_chip
      logic sel_me;

      assign sel_me = (sel_q == 3'(i)) & fwd_en;

      ym2149 u_psg (
         .CLK       (CLK),
         .RESET     (~RESET_N),
         .CE        (CE),
         .CS        (sel_me),
         .BDIR      (BDIR),
         .BC        (BC & sel_me),
         .DI        (DI),
         .DO        (do_w[i]),
         .SEL       (SEL),
         .MODE      (MODE),
         .IOA_in    (IOA_in),
         .IOA_out   (ioa_w[i]),
         .IOB_in    (IOB_in),
         .IOB_out   (iob_w[i]),
         .ACTIVE    (active_w[i]),
         .CHANNEL_A (ch_a[i]),
         .CHANNEL_B (ch_b[i]),
         .CHANNEL_C (ch_c[i])
      );

      psg_activity_hold #(
         .HOLD_CYC (HOLD_CYC)
      ) u_hold (
         .CLK     (CLK),
         .RESET_N (RESET_N),
         .CE      (CE),
         .ACTIVE  (active_w[i]),
         .PLAYING (PLAYING[i])
      );
   end

   // Readback mux from the selected core
   always_comb begin
      DO = '0;
      for (int i = 0; i < NCHIPS; i++) begin
         if (sel_q == 3'(i)) begin
            DO = do_w[i];
         end
      end
   end

   // Mix chip 0 plus every playing chip, normalised by ceil(log2(count))
   always_comb begin
      n_mix = 4'd1;
      sum_a = {3'b000, ch_a[0]};
      sum_b = {3'b000, ch_b[0]};
      sum_c = {3'b000, ch_c[0]};
      for (int i = 1; i < NCHIPS; i++) begin
         if (PLAYING[i]) begin
            n_mix = n_mix + 4'd1;
            sum_a = sum_a + {3'b000, ch_a[i]};
            sum_b = sum_b + {3'b000, ch_b[i]};
            sum_c = sum_c + {3'b000, ch_c[i]};
         end
      end
      shift    = mix_shift(n_mix);
      chan_a_d = 8'(sum_a >> shift);
      chan_b_d = 8'(sum_b >> shift);
      chan_c_d = 8'(sum_c >> shift);
   end

   // Selection and registered mix outputs
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sel_q    <= '0;
         chan_a_q <= '0;
         chan_b_q <= '0;
         chan_c_q <= '0;
      end else begin
         sel_q    <= sel_d;
         chan_a_q <= chan_a_d;
         chan_b_q <= chan_b_d;
         chan_c_q <= chan_c_d;
      end
   end

   assign SELECTED  = sel_q;
   assign CHANNEL_A = chan_a_q;
   assign CHANNEL_B = chan_b_q;
   assign CHANNEL_C = chan_c_q;
   // I/O pins come from chip 0 only
   assign IOA_out   = ioa_w[0];
   assign IOB_out   = iob_w[0];
   assign unused_io = ^{ioa_w, iob_w};

endmodule

// File: tb/tb_multi_psg.sv
// tb_multi_psg: directed bench for a four-chip multi_psg with a 16-tick hold.
module tb_multi_psg;

   localparam int unsigned NCHIPS   = 4;
   localparam int unsigned HOLD_CYC = 16;
`ifdef MULTI_PSG_HOLD_EN
   localparam int unsigned DrainTicks = 18;
`else
   localparam int unsigned DrainTicks = 2;
`endif

   logic              CLK;
   logic              RESET_N;
   logic              CE;
   logic              BDIR;
   logic              BC;
   logic [7:0]        DI;
   logic [7:0]        DO;
   logic              SEL;
   logic              MODE;
   logic [7:0]        IOA_in;
   logic [7:0]        IOB_in;
   logic [7:0]        IOA_out;
   logic [7:0]        IOB_out;
   logic [7:0]        CHANNEL_A;
   logic [7:0]        CHANNEL_B;
   logic [7:0]        CHANNEL_C;
   logic [2:0]        SELECTED;
   logic [NCHIPS-1:0] PLAYING;

   int n_checks;
   int n_fail;

   multi_psg #(
      .NCHIPS   (NCHIPS),
      .HOLD_CYC (HOLD_CYC)
   ) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .CE        (CE),
      .BDIR      (BDIR),
      .BC        (BC),
      .DI        (DI),
      .DO        (DO),
      .SEL       (SEL),
      .MODE      (MODE),
      .IOA_in    (IOA_in),
      .IOB_in    (IOB_in),
      .IOA_out   (IOA_out),
      .IOB_out   (IOB_out),
      .CHANNEL_A (CHANNEL_A),
      .CHANNEL_B (CHANNEL_B),
      .CHANNEL_C (CHANNEL_C),
      .SELECTED  (SELECTED),
      .PLAYING   (PLAYING)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic bus_latch(input logic [7:0] a);
      BDIR = 1'b1;
      BC   = 1'b1;
      DI   = a;
      tick();
      BDIR = 1'b0;
      BC   = 1'b0;
   endtask

   task automatic bus_write(input logic [7:0] d);
      BDIR = 1'b1;
      BC   = 1'b0;
      DI   = d;
      tick();
      BDIR = 1'b0;
   endtask

   task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
      bus_latch(a);
      bus_write(d);
   endtask

   // Read the currently latched register of the selected chip
   task automatic bus_read(output logic [7:0] d);
      BDIR = 1'b0;
      BC   = 1'b1;
      #1;
      d    = DO;
      BC   = 1'b0;
   endtask

   initial begin
      logic [7:0] rdata;
      n_checks = 0;
      n_fail   = 0;
      RESET_N  = 1'b0;
      CE       = 1'b1;
      BDIR     = 1'b0;
      BC       = 1'b0;
      DI       = 8'h00;
      SEL      = 1'b1;
      MODE     = 1'b1;
      IOA_in   = 8'h3C;
      IOB_in   = 8'hA5;

      repeat (3) tick();
      check_eq("rst_selected", 32'(SELECTED), 32'd0);
      check_eq("rst_playing", 32'(PLAYING), 32'd0);
      check_eq("rst_chan_a", 32'(CHANNEL_A), 32'd0);
      RESET_N = 1'b1;
      tick();

      // Chip 0 alone: vol 15 on A (mixer disables tone/noise, so A is a constant level)
      wr_reg(8'd8, 8'h0F);
      check_eq("c0_latency", 32'(CHANNEL_A), 32'd0);
      tick();
      check_eq("c0_chan_a", 32'(CHANNEL_A), 32'd255);
      check_eq("c0_chan_b", 32'(CHANNEL_B), 32'd0);
      check_eq("c0_playing", 32'(PLAYING), 32'd0);
      bus_latch(8'd8);
      bus_read(rdata);
      check_eq("c0_rd_r8", 32'(rdata), 32'h0F);
      wr_reg(8'd14, 8'h5A);
      check_eq("ioa_out", 32'(IOA_out), 32'h5A);
      bus_latch(8'd14);
      bus_read(rdata);
      check_eq("c0_rd_ioa_in", 32'(rdata), 32'h3C);

      // Select chip 1, give it vol 13 and make it active
      bus_latch(8'hFE);
      check_eq("sel_fe", 32'(SELECTED), 32'd1);
      wr_reg(8'd8, 8'h0D);
      wr_reg(8'd7, 8'h1F);
      check_eq("c1_playing", 32'(PLAYING), 32'b0010);
      tick();
      check_eq("mix_2chip", 32'(CHANNEL_A), 32'd191);
      bus_latch(8'd8);
      bus_read(rdata);
      check_eq("c1_rd_r8", 32'(rdata), 32'h0D);

      // Back to chip 0: its latched address (14) must survive both select commands
      bus_latch(8'hFF);
      check_eq("sel_ff", 32'(SELECTED), 32'd0);
      bus_read(rdata);
      check_eq("c0_addr_kept", 32'(rdata), 32'h3C);
      bus_latch(8'd8);
      bus_read(rdata);
      check_eq("c0_r8_untouched", 32'(rdata), 32'h0F);

      // Out-of-range selections are ignored; idx 3 is the last legal one
      bus_latch(8'hF8);
      check_eq("sel_idx7_ign", 32'(SELECTED), 32'd0);
      bus_latch(8'hFB);
      check_eq("sel_idx4_ign", 32'(SELECTED), 32'd0);
      bus_latch(8'hFC);
      check_eq("sel_idx3", 32'(SELECTED), 32'd3);

      // Chip 2 joins with vol 11: (255+128+64)>>2
      bus_latch(8'hFD);
      wr_reg(8'd8, 8'h0B);
      wr_reg(8'd7, 8'h1F);
      tick();
      check_eq("c2_playing", 32'(PLAYING), 32'b0110);
      check_eq("mix_3chip", 32'(CHANNEL_A), 32'd111);

      // Chip 1 goes quiet
      bus_latch(8'hFE);
      wr_reg(8'd7, 8'h3F);
`ifdef MULTI_PSG_HOLD_EN
      check_eq("hold_start", 32'(PLAYING), 32'b0110);
      repeat (15) tick();
      check_eq("hold_last", 32'(PLAYING), 32'b0110);
      check_eq("hold_mix", 32'(CHANNEL_A), 32'd111);
      tick();
      check_eq("hold_drop", 32'(PLAYING), 32'b0100);
`else
      check_eq("stop_drop", 32'(PLAYING), 32'b0100);
`endif
      tick();
      check_eq("mix_c0_c2", 32'(CHANNEL_A), 32'd159);

      // Chip 2 goes quiet too: mix reverts to chip 0 pass-through
      bus_latch(8'hFD);
      wr_reg(8'd7, 8'h3F);
      repeat (DrainTicks) tick();
      check_eq("revert_playing", 32'(PLAYING), 32'd0);
      check_eq("revert_chan_a", 32'(CHANNEL_A), 32'd255);

      // Asynchronous reset between clock edges
      bus_latch(8'hFE);
      wr_reg(8'd7, 8'h1F);
      tick();
      check_eq("pre_rst_mix", 32'(CHANNEL_A), 32'd191);
      @(posedge CLK);
      #2;
      RESET_N = 1'b0;
      #1;
      check_eq("arst_chan_a", 32'(CHANNEL_A), 32'd0);
      check_eq("arst_selected", 32'(SELECTED), 32'd0);
      check_eq("arst_playing", 32'(PLAYING), 32'd0);
      tick();
      RESET_N = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
